// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester ids, defaults.
// No logic or latency of its own.
// No flow control of its own.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    localparam int DATA_W_DEF = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the port not granted last.
// Purely combinational, zero latency.
// No backpressure; the caller decides when a grant is consumed.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |req;
        if (req == 2'b11) begin
            grant_id = ~last_grant;
        end else begin
            grant_id = req[PORT_LD] ? PORT_LD : PORT_CPU;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between CPU and loader; optional counters under DMEM_ARB_STATS_EN.
// Latency: req in IDLE cycle t -> ack in cycle t+MEM_LAT+2; back-to-back handoff with no idle gap.
// Backpressure: requesters hold req until a one-cycle ack; cpu_stall freezes the pipeline meanwhile.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [15:0]       ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_cpu_grants,
    output logic [15:0]       stat_ld_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic                last_grant_q, last_grant_d;
    logic [LAT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ld_rdata_q, ld_rdata_d;

    logic [1:0]          arb_req;
    logic                grant_valid;
    logic                grant_id;
    logic                take;
    logic [15:0]         sel_addr;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[15:ADDR_W+1], cpu_addr[0],
                                ld_addr[15:ADDR_W+1], ld_addr[0]};

    // In RESP the current winner's req belongs to the access being acked, so only the other port competes.
    always_comb begin
        arb_req = {ld_req, cpu_req};
        if (state_q == ST_RESP) begin
            arb_req[winner_q] = 1'b0;
        end
    end

    rr_arb2 u_rr_arb2 (
        .req         (arb_req),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign take     = grant_valid && ((state_q == ST_IDLE) || (state_q == ST_RESP));
    assign sel_addr = (grant_id == PORT_LD) ? ld_addr : cpu_addr;

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        ld_rdata_d   = ld_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                lat_cnt_d = LAT_W'(MEM_LAT - 1);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt_q == '0) begin
                    if (!we_q) begin
                        if (winner_q == PORT_CPU) begin
                            cpu_rdata_d = mem_rdata;
                        end else begin
                            ld_rdata_d = mem_rdata;
                        end
                    end
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                last_grant_d = winner_q;
                state_d      = grant_valid ? ST_ISSUE : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            winner_d = grant_id;
            we_d     = (grant_id == PORT_LD) ? ld_we : cpu_we;
            addr_d   = sel_addr[ADDR_W:1];
            wdata_d  = (grant_id == PORT_LD) ? ld_wdata : cpu_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            winner_q     <= PORT_CPU;
            last_grant_q <= PORT_LD;
            lat_cnt_q    <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            ld_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            ld_rdata_q   <= ld_rdata_d;
        end
    end

    assign mem_en    = (state_q == ST_ISSUE);
    assign mem_we    = we_q & mem_en;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_ack   = (state_q == ST_RESP) && (winner_q == PORT_CPU);
    assign ld_ack    = (state_q == ST_RESP) && (winner_q == PORT_LD);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign busy      = (state_q != ST_IDLE);

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_q, stat_cpu_d;
    logic [15:0] stat_ld_q, stat_ld_d;
    logic [15:0] stat_conf_q, stat_conf_d;

    always_comb begin
        stat_cpu_d  = stat_cpu_q;
        stat_ld_d   = stat_ld_q;
        stat_conf_d = stat_conf_q;
        if (cpu_ack) begin
            stat_cpu_d = sat_inc16(stat_cpu_q);
        end
        if (ld_ack) begin
            stat_ld_d = sat_inc16(stat_ld_q);
        end
        if (((state_q == ST_IDLE) || (state_q == ST_RESP)) && cpu_req && ld_req) begin
            stat_conf_d = sat_inc16(stat_conf_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stat_cpu_q  <= '0;
            stat_ld_q   <= '0;
            stat_conf_q <= '0;
        end else begin
            stat_cpu_q  <= stat_cpu_d;
            stat_ld_q   <= stat_ld_d;
            stat_conf_q <= stat_conf_d;
        end
    end

    assign stat_cpu_grants = stat_cpu_q;
    assign stat_ld_grants  = stat_ld_q;
    assign stat_conflicts  = stat_conf_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default-latency instance plus a MEM_LAT=3 instance on shared inputs.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset_n;
    logic        cpu_req, cpu_we;
    logic [15:0] cpu_addr, cpu_wdata;
    logic        ld_req, ld_we;
    logic [15:0] ld_addr, ld_wdata;

    logic        cpu_ack, cpu_stall, ld_ack, mem_en, mem_we, busy;
    logic [15:0] cpu_rdata, ld_rdata, mem_wdata, mem_rdata;
    logic [9:0]  mem_addr;

    logic        cpu_ack_3, mem_en_3, mem_we_3, busy_3;
    logic        unused_stall_3, unused_ld_ack_3;
    logic [15:0] unused_cpu_rdata_3, unused_ld_rdata_3, mem_wdata_3, mem_rdata_3;
    logic [9:0]  mem_addr_3;

`ifdef DMEM_ARB_STATS_EN
    logic [15:0] stat_cpu_grants, stat_ld_grants, stat_conflicts;
    logic [15:0] unused_sc_3, unused_sl_3, unused_sx_3;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter u_dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(ld_ack), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_grants(stat_cpu_grants), .stat_ld_grants(stat_ld_grants),
        .stat_conflicts(stat_conflicts)
`endif
    );

    dmem_arbiter #(.MEM_LAT(3)) u_dut3 (
        .clock(clock), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack_3), .cpu_rdata(unused_cpu_rdata_3), .cpu_stall(unused_stall_3),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_ack(unused_ld_ack_3), .ld_rdata(unused_ld_rdata_3),
        .mem_en(mem_en_3), .mem_we(mem_we_3), .mem_addr(mem_addr_3), .mem_wdata(mem_wdata_3),
        .mem_rdata(mem_rdata_3), .busy(busy_3)
`ifdef DMEM_ARB_STATS_EN
        , .stat_cpu_grants(unused_sc_3), .stat_ld_grants(unused_sl_3),
        .stat_conflicts(unused_sx_3)
`endif
    );

    // Memory models: 1-cycle and 3-cycle read latency.
    logic [15:0] mem1 [0:1023];
    logic [15:0] rd1;
    logic [15:0] mem3 [0:1023];
    logic [15:0] p0, p1, p2;

    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem1[mem_addr] <= mem_wdata;
            else        rd1 <= mem1[mem_addr];
        end
    end
    assign mem_rdata = rd1;

    always @(posedge clock) begin
        if (mem_en_3) begin
            if (mem_we_3) mem3[mem_addr_3] <= mem_wdata_3;
            else          p0 <= mem3[mem_addr_3];
        end
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata_3 = p2;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        cpu_req = 1'b0;
        ld_req  = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        next_cycle();
        @(negedge clock);
        n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en got %b want 0", mem_en); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 10'd0) begin n_bad++; $display("FAIL rst_mem_addr got %0d want 0", mem_addr); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
        n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ack got %b want 0", cpu_ack); end
        n_cmp++; if (ld_ack !== 1'b0) begin n_bad++; $display("FAIL rst_ld_ack got %b want 0", ld_ack); end
        n_cmp++; if (cpu_rdata !== 16'd0) begin n_bad++; $display("FAIL rst_cpu_rdata got %h want 0", cpu_rdata); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_stall got %b want 0", cpu_stall); end
        n_cmp++; if (busy_3 !== 1'b0) begin n_bad++; $display("FAIL rst_busy3 got %b want 0", busy_3); end
        next_cycle();
        reset_n = 1'b1;
        next_cycle();
    endtask

    // Loader writes word 0 = 5; used by later reads.
    task automatic test_ld_write;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin ld_req = 1; ld_we = 1; ld_addr = 16'd0; ld_wdata = 16'd5; end
            if (c == 4) ld_req = 0;
            @(negedge clock);
            n_cmp++; if (ld_ack !== (c == 3)) begin n_bad++; $display("FAIL ldw_ack c=%0d got %b", c, ld_ack); end
            n_cmp++; if (mem_en !== (c == 1)) begin n_bad++; $display("FAIL ldw_mem_en c=%0d got %b", c, mem_en); end
            n_cmp++; if (cpu_stall !== 1'b0) begin n_bad++; $display("FAIL ldw_cpu_stall c=%0d got %b want 0", c, cpu_stall); end
            if (c == 1) begin
                n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL ldw_mem_we got %b want 1", mem_we); end
                n_cmp++; if (mem_wdata !== 16'd5) begin n_bad++; $display("FAIL ldw_wdata got %0d want 5", mem_wdata); end
            end
            next_cycle();
        end
        ld_we = 0;
    endtask

    task automatic test_cpu_read;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'd0; end
            if (c == 4) cpu_req = 0;
            @(negedge clock);
            n_cmp++; if (cpu_ack !== (c == 3)) begin n_bad++; $display("FAIL rd_ack c=%0d got %b", c, cpu_ack); end
            n_cmp++; if (cpu_stall !== (c <= 2)) begin n_bad++; $display("FAIL rd_stall c=%0d got %b", c, cpu_stall); end
            n_cmp++; if (mem_en !== (c == 1)) begin n_bad++; $display("FAIL rd_mem_en c=%0d got %b", c, mem_en); end
            n_cmp++; if (busy !== (c >= 1 && c <= 3)) begin n_bad++; $display("FAIL rd_busy c=%0d got %b", c, busy); end
            if (c == 1) begin
                n_cmp++; if (mem_addr !== 10'd0) begin n_bad++; $display("FAIL rd_mem_addr got %0d want 0", mem_addr); end
                n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rd_mem_we got %b want 0", mem_we); end
            end
            if (c == 3) begin
                n_cmp++; if (cpu_rdata !== 16'd5) begin n_bad++; $display("FAIL rd_rdata got %0d want 5", cpu_rdata); end
            end
            next_cycle();
        end
    endtask

    // Write byte addr 4 (word 2) = 7, then read it back through a wrapped, odd address.
    task automatic test_cpu_write;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_we = 1; cpu_addr = 16'd4; cpu_wdata = 16'd7; end
            if (c == 4) begin cpu_req = 0; cpu_we = 0; end
            @(negedge clock);
            n_cmp++; if (cpu_ack !== (c == 3)) begin n_bad++; $display("FAIL wr_ack c=%0d got %b", c, cpu_ack); end
            n_cmp++; if (mem_en !== (c == 1)) begin n_bad++; $display("FAIL wr_mem_en c=%0d got %b", c, mem_en); end
            if (c == 1) begin
                n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL wr_mem_we got %b want 1", mem_we); end
                n_cmp++; if (mem_addr !== 10'd2) begin n_bad++; $display("FAIL wr_mem_addr got %0d want 2", mem_addr); end
                n_cmp++; if (mem_wdata !== 16'd7) begin n_bad++; $display("FAIL wr_wdata got %0d want 7", mem_wdata); end
            end
            if (c == 3) begin
                n_cmp++; if (cpu_rdata !== 16'd5) begin n_bad++; $display("FAIL wr_rdata_kept got %0d want 5", cpu_rdata); end
            end
            next_cycle();
        end
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'hF805; end
            if (c == 4) cpu_req = 0;
            @(negedge clock);
            n_cmp++; if (cpu_ack !== (c == 3)) begin n_bad++; $display("FAIL rb_ack c=%0d got %b", c, cpu_ack); end
            if (c == 1) begin
                n_cmp++; if (mem_addr !== 10'd2) begin n_bad++; $display("FAIL rb_wrap_addr got %0d want 2", mem_addr); end
            end
            if (c == 3) begin
                n_cmp++; if (cpu_rdata !== 16'd7) begin n_bad++; $display("FAIL rb_rdata got %0d want 7", cpu_rdata); end
            end
            next_cycle();
        end
    endtask

    task automatic test_tie;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c == 0) begin
                cpu_req = 1; cpu_we = 0; cpu_addr = 16'd0;
                ld_req = 1; ld_we = 0; ld_addr = 16'd4;
            end
            if (c == 4) cpu_req = 0;
            if (c == 7) ld_req = 0;
            @(negedge clock);
            n_cmp++; if (cpu_ack !== (c == 3)) begin n_bad++; $display("FAIL tie_cpu_ack c=%0d got %b", c, cpu_ack); end
            n_cmp++; if (ld_ack !== (c == 6)) begin n_bad++; $display("FAIL tie_ld_ack c=%0d got %b", c, ld_ack); end
            n_cmp++; if (mem_en !== (c == 1 || c == 4)) begin n_bad++; $display("FAIL tie_mem_en c=%0d got %b", c, mem_en); end
            n_cmp++; if (busy !== (c >= 1 && c <= 6)) begin n_bad++; $display("FAIL tie_busy c=%0d got %b", c, busy); end
            if (c == 4) begin
                n_cmp++; if (mem_addr !== 10'd2) begin n_bad++; $display("FAIL tie_ld_addr got %0d want 2", mem_addr); end
            end
            if (c == 6) begin
                n_cmp++; if (ld_rdata !== 16'd7) begin n_bad++; $display("FAIL tie_ld_rdata got %0d want 7", ld_rdata); end
            end
            next_cycle();
        end
    endtask

    // Loader drops req after one cycle: the access still completes with an ack.
    task automatic test_drop_early;
        for (int c = 0; c < 6; c++) begin
            if (c == 0) begin ld_req = 1; ld_we = 0; ld_addr = 16'd0; end
            if (c == 1) ld_req = 0;
            @(negedge clock);
            n_cmp++; if (ld_ack !== (c == 3)) begin n_bad++; $display("FAIL drop_ack c=%0d got %b", c, ld_ack); end
            n_cmp++; if (busy !== (c >= 1 && c <= 3)) begin n_bad++; $display("FAIL drop_busy c=%0d got %b", c, busy); end
            if (c == 3) begin
                n_cmp++; if (ld_rdata !== 16'd5) begin n_bad++; $display("FAIL drop_rdata got %0d want 5", ld_rdata); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back;
        int n_c;
        int n_l;
        logic exp_c, exp_l;
        n_c = 0;
        n_l = 0;
        do_reset();
        for (int c = 0; c < 27; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'd0; end
            if (c == 1) begin ld_req = 1; ld_we = 0; ld_addr = 16'd4; end
            if (c == 22) cpu_req = 0;
            if (c == 25) ld_req = 0;
            @(negedge clock);
            exp_c = (c >= 3) && (c <= 24) && (c % 3 == 0) && ((c / 3) % 2 == 1);
            exp_l = (c >= 3) && (c <= 24) && (c % 3 == 0) && ((c / 3) % 2 == 0);
            if (cpu_ack === 1'b1) n_c++;
            if (ld_ack === 1'b1) n_l++;
            n_cmp++; if (cpu_ack !== exp_c) begin n_bad++; $display("FAIL b2b_cpu_ack c=%0d got %b want %b", c, cpu_ack, exp_c); end
            n_cmp++; if (ld_ack !== exp_l) begin n_bad++; $display("FAIL b2b_ld_ack c=%0d got %b want %b", c, ld_ack, exp_l); end
            n_cmp++; if (busy !== (c >= 1 && c <= 24)) begin n_bad++; $display("FAIL b2b_busy c=%0d got %b", c, busy); end
            next_cycle();
        end
        n_cmp++; if (n_c !== 4) begin n_bad++; $display("FAIL b2b_cpu_count got %0d want 4", n_c); end
        n_cmp++; if (n_l !== 4) begin n_bad++; $display("FAIL b2b_ld_count got %0d want 4", n_l); end
`ifdef DMEM_ARB_STATS_EN
        n_cmp++; if (stat_cpu_grants !== 16'd4) begin n_bad++; $display("FAIL stat_cpu got %0d want 4", stat_cpu_grants); end
        n_cmp++; if (stat_ld_grants !== 16'd4) begin n_bad++; $display("FAIL stat_ld got %0d want 4", stat_ld_grants); end
        n_cmp++; if (stat_conflicts !== 16'd7) begin n_bad++; $display("FAIL stat_conf got %0d want 7", stat_conflicts); end
`endif
    endtask

    // MEM_LAT=3 instance: reset in the middle of WAIT discards the access.
    task automatic test_reset_mid;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            if (c == 0) begin cpu_req = 1; cpu_we = 0; cpu_addr = 16'd0; end
            @(negedge clock);
            n_cmp++; if (mem_en_3 !== (c == 1)) begin n_bad++; $display("FAIL mid_mem_en c=%0d got %b", c, mem_en_3); end
            n_cmp++; if (busy_3 !== (c >= 1)) begin n_bad++; $display("FAIL mid_busy c=%0d got %b", c, busy_3); end
            next_cycle();
        end
        reset_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        n_cmp++; if (busy_3 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", busy_3); end
        n_cmp++; if (mem_en_3 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_mem_en got %b want 0", mem_en_3); end
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_cmp++; if (cpu_ack_3 !== 1'b0) begin n_bad++; $display("FAIL mid_no_ack c=%0d got %b want 0", c, cpu_ack_3); end
            next_cycle();
        end
        for (int c = 0; c < 8; c++) begin
            if (c == 0) cpu_req = 1;
            if (c == 6) cpu_req = 0;
            @(negedge clock);
            n_cmp++; if (cpu_ack_3 !== (c == 5)) begin n_bad++; $display("FAIL re_ack c=%0d got %b", c, cpu_ack_3); end
            n_cmp++; if (mem_en_3 !== (c == 1)) begin n_bad++; $display("FAIL re_mem_en c=%0d got %b", c, mem_en_3); end
            n_cmp++; if (busy_3 !== (c >= 1 && c <= 5)) begin n_bad++; $display("FAIL re_busy c=%0d got %b", c, busy_3); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_ld_write();
        test_cpu_read();
        test_cpu_write();
        test_tie();
        test_drop_early();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
